// File: rtl/l2_shared_memory.sv
// Shared L2 responder: arbitrates two L1 word ports onto one single-ported
// word memory, drives per-core busy stalls and broadcasts snoop info.
//
// Ports:
//   clk, reset (async, active-low)
//   coreX_read_request / coreX_write_request / coreX_word_address /
//   coreX_write_word                       : L1 request side (X = 0,1)
//   coreX_read_word                        : shared registered read data
//   coreX_busy                             : stall to coreX's L1
//   coreX_others_read_request / _write_request / _block_tag / _block_index
//                                          : other core's granted request
//   L2_statistics                          : grant counters
//
// Optional feature: define L2_STATS_EN to build the grant counters
// {core0 rd, core0 wr, core1 rd, core1 wr} (8 bits each, wrapping).
// Without it L2_statistics is tied to 0.
module l2_shared_memory #(
    parameter int n      = 32,
    parameter int addr_w = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core0_read_request,
    input  logic              core0_write_request,
    input  logic [addr_w-1:0] core0_word_address,
    input  logic [n-1:0]      core0_write_word,
    output logic [n-1:0]      core0_read_word,
    output logic              core0_busy,
    output logic              core0_others_read_request,
    output logic              core0_others_write_request,
    output logic [4:0]        core0_others_block_tag,
    output logic [5:0]        core0_others_block_index,
    input  logic              core1_read_request,
    input  logic              core1_write_request,
    input  logic [addr_w-1:0] core1_word_address,
    input  logic [n-1:0]      core1_write_word,
    output logic [n-1:0]      core1_read_word,
    output logic              core1_busy,
    output logic              core1_others_read_request,
    output logic              core1_others_write_request,
    output logic [4:0]        core1_others_block_tag,
    output logic [5:0]        core1_others_block_index,
    output logic [31:0]       L2_statistics
);

    localparam int DEPTH = 1 << addr_w;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;

    logic req0, req1;
    logic grant0, grant1;

    logic [addr_w-1:0] sel_addr;
    logic [n-1:0]      sel_wdata;
    logic              we;

    logic [n-1:0] mem [0:DEPTH-1];
    logic [n-1:0] read_word_q;

    assign req0   = core0_read_request | core0_write_request;
    assign req1   = core1_read_request | core1_write_request;
    assign grant0 = (state_q == GRANT0);
    assign grant1 = (state_q == GRANT1);

    // Arbitration: alternate on ties, no preemption while holder requests.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1)
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                else if (req0)
                    state_d = GRANT0;
                else if (req1)
                    state_d = GRANT1;
            end
            GRANT0: begin
                if (!req0) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            GRANT1: begin
                if (!req1) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign core0_busy = req0 & ~grant0;
    assign core1_busy = req1 & ~grant1;

    assign sel_addr  = grant1 ? core1_word_address : core0_word_address;
    assign sel_wdata = grant1 ? core1_write_word   : core0_write_word;
    assign we        = (grant0 & core0_write_request)
                     | (grant1 & core1_write_request);

    // Memory has no reset; the reset term keeps an edge seen under reset
    // from committing a write.
    always_ff @(posedge clk) begin
        if (we && reset)
            mem[sel_addr] <= sel_wdata;
    end

    // Read-before-write: the register samples the pre-write contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            read_word_q <= '0;
        else if (grant0 || grant1)
            read_word_q <= mem[sel_addr];
    end

    assign core0_read_word = read_word_q;
    assign core1_read_word = read_word_q;

    // Snoop: only the granted request is broadcast to the other core.
    assign core1_others_read_request  = grant0 & core0_read_request;
    assign core1_others_write_request = grant0 & core0_write_request;
    assign core1_others_block_tag     =
        grant0 ? core0_word_address[addr_w-1 -: 5] : 5'd0;
    assign core1_others_block_index   =
        grant0 ? core0_word_address[9:4] : 6'd0;

    assign core0_others_read_request  = grant1 & core1_read_request;
    assign core0_others_write_request = grant1 & core1_write_request;
    assign core0_others_block_tag     =
        grant1 ? core1_word_address[addr_w-1 -: 5] : 5'd0;
    assign core0_others_block_index   =
        grant1 ? core1_word_address[9:4] : 6'd0;

`ifdef L2_STATS_EN
    logic       first_q;
    logic [7:0] cnt_r0, cnt_w0, cnt_r1, cnt_w1;

    // first_q marks the first cycle of a fresh grant; the request type
    // seen in that cycle is what gets counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_q <= 1'b0;
            cnt_r0  <= '0;
            cnt_w0  <= '0;
            cnt_r1  <= '0;
            cnt_w1  <= '0;
        end else begin
            first_q <= (state_q == IDLE) && (state_d != IDLE);
            if (first_q && grant0) begin
                if (core0_read_request)
                    cnt_r0 <= cnt_r0 + 8'd1;
                if (core0_write_request)
                    cnt_w0 <= cnt_w0 + 8'd1;
            end
            if (first_q && grant1) begin
                if (core1_read_request)
                    cnt_r1 <= cnt_r1 + 8'd1;
                if (core1_write_request)
                    cnt_w1 <= cnt_w1 + 8'd1;
            end
        end
    end

    assign L2_statistics = {cnt_r0, cnt_w0, cnt_r1, cnt_w1};
`else
    assign L2_statistics = 32'd0;
`endif

endmodule

// File: tb/tb_l2_shared_memory.sv
// Directed testbench for l2_shared_memory.
// Linear stimulus with immediate-assertion checks and a summary line.
module tb_l2_shared_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c0_rd = 1'b0, c0_wr = 1'b0;
    logic [14:0] c0_addr = '0;
    logic [31:0] c0_wd = '0;
    logic        c1_rd = 1'b0, c1_wr = 1'b0;
    logic [14:0] c1_addr = '0;
    logic [31:0] c1_wd = '0;

    logic [31:0] rd0, rd1, stats;
    logic        busy0, busy1;
    logic        o0_rd, o0_wr, o1_rd, o1_wr;
    logic [4:0]  o0_tag, o1_tag;
    logic [5:0]  o0_idx, o1_idx;

    int ncmp = 0;
    int nerr = 0;

`ifdef L2_STATS_EN
    localparam logic [31:0] STATS_EXP = 32'h0300_0001;
`else
    localparam logic [31:0] STATS_EXP = 32'h0;
`endif

    l2_shared_memory dut (
        .clk                        (clk),
        .reset                      (reset),
        .core0_read_request         (c0_rd),
        .core0_write_request        (c0_wr),
        .core0_word_address         (c0_addr),
        .core0_write_word           (c0_wd),
        .core0_read_word            (rd0),
        .core0_busy                 (busy0),
        .core0_others_read_request  (o0_rd),
        .core0_others_write_request (o0_wr),
        .core0_others_block_tag     (o0_tag),
        .core0_others_block_index   (o0_idx),
        .core1_read_request         (c1_rd),
        .core1_write_request        (c1_wr),
        .core1_word_address         (c1_addr),
        .core1_write_word           (c1_wd),
        .core1_read_word            (rd1),
        .core1_busy                 (busy1),
        .core1_others_read_request  (o1_rd),
        .core1_others_write_request (o1_wr),
        .core1_others_block_tag     (o1_tag),
        .core1_others_block_index   (o1_idx),
        .L2_statistics              (stats)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic wr(input bit c, input logic [14:0] a,
                      input logic [31:0] d);
        if (c) begin
            c1_wr = 1'b1; c1_addr = a; c1_wd = d;
        end else begin
            c0_wr = 1'b1; c0_addr = a; c0_wd = d;
        end
        tick();
        tick();
        c0_wr = 1'b0;
        c1_wr = 1'b0;
        tick();
    endtask

    task automatic rd(input bit c, input logic [14:0] a);
        if (c) begin
            c1_rd = 1'b1; c1_addr = a;
        end else begin
            c0_rd = 1'b1; c0_addr = a;
        end
        tick();
        tick();
        c0_rd = 1'b0;
        c1_rd = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_busy", {30'd0, busy0, busy1}, 32'h0);
        chk("rst_snoop", {o0_rd, o0_wr, o1_rd, o1_wr, o0_tag, o0_idx,
                          o1_tag, o1_idx}, 32'h0);
        chk("rst_stats", stats, 32'h0);

        // Preload through the write ports.
        wr(1'b0, 15'h0123, 32'hDEAD_BEEF);
        for (int i = 0; i < 16; i++)
            wr(1'b1, 15'h7FF0 + 15'(i), 32'hC0DE_0000 + i);

        // Single core0 read after reset.
        do_reset();
        c0_rd = 1'b1; c0_addr = 15'h0123;
        #1;
        chk("rd_arb_busy0", {31'd0, busy0}, 32'h1);
        chk("rd_arb_snoop", {31'd0, o1_rd}, 32'h0);
        tick();
        chk("rd_grant_busy0", {31'd0, busy0}, 32'h0);
        chk("rd_snoop_rd", {31'd0, o1_rd}, 32'h1);
        chk("rd_snoop_tag", {27'd0, o1_tag}, 32'h00);
        chk("rd_snoop_idx", {26'd0, o1_idx}, 32'h12);
        chk("rd_self_snoop", {31'd0, o0_rd}, 32'h0);
        tick();
        chk("rd_data0", rd0, 32'hDEAD_BEEF);
        chk("rd_data1", rd1, 32'hDEAD_BEEF);
        c0_rd = 1'b0;
        tick();

        // Tie after reset: core0 first, core1 waits.
        do_reset();
        c0_rd = 1'b1; c0_addr = 15'h0123;
        c1_rd = 1'b1; c1_addr = 15'h7FF0;
        #1;
        chk("tie_arb_busy", {30'd0, busy0, busy1}, 32'h3);
        tick();
        chk("tie_g0_busy", {30'd0, busy0, busy1}, 32'h1);
        chk("tie_g0_o0rd", {31'd0, o0_rd}, 32'h0);
        tick();
        c0_rd = 1'b0;
        #1;
        chk("tie_g0_hold_busy1", {31'd0, busy1}, 32'h1);
        tick();
        chk("tie_idle_busy", {30'd0, busy0, busy1}, 32'h1);
        chk("tie_idle_snoop", {30'd0, o0_rd, o1_rd}, 32'h0);
        tick();
        chk("tie_g1_busy1", {31'd0, busy1}, 32'h0);
        chk("g1_snoop_rd", {31'd0, o0_rd}, 32'h1);
        chk("g1_snoop_tag", {27'd0, o0_tag}, 32'h1F);
        chk("g1_snoop_idx", {26'd0, o0_idx}, 32'h3F);
        chk("g1_other_snoop", {31'd0, o1_rd}, 32'h0);

        // 16-word refill burst from core1, data trails address by 1.
        for (int i = 0; i < 16; i++) begin
            c1_addr = 15'h7FF0 + 15'(i);
            #1;
            chk($sformatf("burst_busy1_%0d", i), {31'd0, busy1}, 32'h0);
            if (i > 0)
                chk($sformatf("burst_data_%0d", i - 1), rd1,
                    32'hC0DE_0000 + i - 1);
            tick();
        end
        chk("burst_data_15", rd1, 32'hC0DE_000F);
        c1_rd = 1'b0;
        tick();

        // Next tie after core1 released goes to core0.
        c0_rd = 1'b1; c0_addr = 15'h0010;
        c1_rd = 1'b1; c1_addr = 15'h0020;
        tick();
        chk("tie2_busy", {30'd0, busy0, busy1}, 32'h1);
        c0_rd = 1'b0;
        c1_rd = 1'b0;
        tick();

        // Two-cycle write-through from core0.
        c0_wr = 1'b1; c0_addr = 15'h0400; c0_wd = 32'hA5A5_A5A5;
        #1;
        chk("wt_arb_snoop", {31'd0, o1_wr}, 32'h0);
        tick();
        chk("wt_c1_snoop_wr", {31'd0, o1_wr}, 32'h1);
        chk("wt_c1_snoop_tag", {27'd0, o1_tag}, 32'h01);
        chk("wt_c1_snoop_idx", {26'd0, o1_idx}, 32'h00);
        chk("wt_c1_snoop_rd", {31'd0, o1_rd}, 32'h0);
        tick();
        chk("wt_c2_snoop_wr", {31'd0, o1_wr}, 32'h1);
        c0_wr = 1'b0;
        tick();
        chk("wt_idle_snoop", {31'd0, o1_wr}, 32'h0);
        c1_rd = 1'b1; c1_addr = 15'h0400;
        tick();
        tick();
        chk("wt_readback", rd1, 32'hA5A5_A5A5);
        c1_rd = 1'b0;
        tick();

        // Same-cycle read and write: old data first.
        c0_rd = 1'b1; c0_wr = 1'b1;
        c0_addr = 15'h0400; c0_wd = 32'h1234_5678;
        tick();
        tick();
        chk("rbw_old", rd0, 32'hA5A5_A5A5);
        tick();
        chk("rbw_new", rd0, 32'h1234_5678);
        c0_rd = 1'b0; c0_wr = 1'b0;
        tick();

        // Reset in the middle of a core0 write.
        c0_wr = 1'b1; c0_addr = 15'h0400; c0_wd = 32'hBAD0_BAD0;
        tick();
        chk("rstw_pre_snoop", {31'd0, o1_wr}, 32'h1);
        reset = 1'b0;
        #1;
        chk("rstw_rd0", rd0, 32'h0);
        chk("rstw_snoop", {o1_rd, o1_wr, o1_tag, o1_idx}, 32'h0);
        tick();
        c0_wr = 1'b0;
        reset = 1'b1;
        #1;
        chk("rstw_busy", {30'd0, busy0, busy1}, 32'h0);
        rd(1'b1, 15'h0400);
        chk("rstw_mem_kept", rd1, 32'h1234_5678);

        // Grant counters.
        do_reset();
        chk("stats_reset", stats, 32'h0);
        rd(1'b0, 15'h0001);
        rd(1'b0, 15'h0002);
        rd(1'b0, 15'h0003);
        wr(1'b1, 15'h0004, 32'h0000_0044);
        chk("stats_count", stats, STATS_EXP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
